// File: rtl/tron_round_if.sv
// tron_round_if
//   Handshake and status bundle between the Tron round controller and the rest of the game.
//
//   Ports (seen from the controller, modport slave):
//     start_ack            in   debounced Start/Acknowledge pulse
//     p1_crash, p2_crash   in   crash flags from the movement datapath
//     step_en              out  movement-advance pulse
//     arena_clear          out  arena clear pulse issued before each round
//     q_I .. q_Done        out  one-hot state flags
//     countdown            out  countdown digit (3, 2, 1), or 0 when no countdown is running
//     p1_score, p2_score   out  round-win counts
//     round_winner         out  result of the last round (01 P1, 10 P2, 11 draw, 00 none)
//
//   The master modport is the driving side, used by the game top level or a testbench.
interface tron_round_if;
  logic       start_ack;
  logic       p1_crash;
  logic       p2_crash;
  logic       step_en;
  logic       arena_clear;
  logic       q_I;
  logic       q_Count;
  logic       q_Driving;
  logic       q_Collision;
  logic       q_Done;
  logic [1:0] countdown;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] round_winner;

  modport master (
    output start_ack, p1_crash, p2_crash,
    input  step_en, arena_clear, q_I, q_Count, q_Driving, q_Collision, q_Done,
    input  countdown, p1_score, p2_score, round_winner
  );

  modport slave (
    input  start_ack, p1_crash, p2_crash,
    output step_en, arena_clear, q_I, q_Count, q_Driving, q_Collision, q_Done,
    output countdown, p1_score, p2_score, round_winner
  );
endinterface

// File: rtl/tron_round_ctrl.sv
// tron_round_ctrl
//   Match and round sequencer for a two-player Tron game. It runs the match as follows:
//     1. Start: wait for a start.
//     2. Countdown: count down 3-2-1.
//     3. Drive: pace the movement datapath with step_en.
//     4. Score: judge crashes and score the round.
//     5. Finish: end the match when a player reaches WIN_SCORE.
//
//   Ports:
//     board_clk  in  system clock
//     Reset      in  asynchronous, active-high reset
//     bus        tron_round_if.slave (start_ack, crash flags in; pulses, state flags, scores out)
//
//   Parameters:
//     STEP_DIV   board_clk cycles between step_en pulses while driving
//     CD_TICKS   board_clk cycles per countdown digit
//     WIN_SCORE  round wins that end the match
//
//   Build option:
//     TRON_DRAW_NOSCORE_EN  when defined, a draw scores for neither player.
//                           When undefined, a draw scores for both players, with saturation.
module tron_round_ctrl #(
  parameter int STEP_DIV  = 4,
  parameter int CD_TICKS  = 8,
  parameter int WIN_SCORE = 3
) (
  input logic        board_clk,
  input logic        Reset,
  tron_round_if.slave bus
);

  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int CD_W   = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(CD_TICKS - 1);
  localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

  // One-hot encoding, so each q_* flag is a state flop bit.
  typedef enum logic [4:0] {
    S_I     = 5'b10000,
    S_COUNT = 5'b01000,
    S_DRIVE = 5'b00100,
    S_COLL  = 5'b00010,
    S_DONE  = 5'b00001
  } state_e;

  state_e            state_q,       state_d;
  logic [CD_W-1:0]   cd_cnt_q,      cd_cnt_d;
  logic [STEP_W-1:0] step_cnt_q,    step_cnt_d;
  logic              step_en_q,     step_en_d;
  logic              sample_q,      sample_d;
  logic              arena_clear_q, arena_clear_d;
  logic [1:0]        countdown_q,   countdown_d;
  logic [3:0]        p1_score_q,    p1_score_d;
  logic [3:0]        p2_score_q,    p2_score_d;
  logic [1:0]        winner_q,      winner_d;

  // Score increment that saturates at WIN_SCORE.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    if (s >= WIN) begin
      sat_inc = s;
    end else begin
      sat_inc = s + 4'd1;
    end
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    step_cnt_d    = step_cnt_q;
    step_en_d     = 1'b0;
    sample_d      = 1'b0;
    arena_clear_d = 1'b0;
    countdown_d   = countdown_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    winner_d      = winner_q;

    case (state_q)
      S_I: begin
        if (bus.start_ack) begin
          state_d       = S_COUNT;
          p1_score_d    = 4'd0;
          p2_score_d    = 4'd0;
          winner_d      = 2'b00;
          arena_clear_d = 1'b1;
          countdown_d   = 2'd3;
          cd_cnt_d      = {CD_W{1'b0}};
        end else begin
          state_d = S_I;
        end
      end

      S_COUNT: begin
        if (cd_cnt_q == CD_LAST) begin
          cd_cnt_d = {CD_W{1'b0}};
          if (countdown_q == 2'd1) begin
            state_d     = S_DRIVE;
            countdown_d = 2'd0;
            step_cnt_d  = {STEP_W{1'b0}};
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          cd_cnt_d = cd_cnt_q + {{(CD_W-1){1'b0}}, 1'b1};
        end
      end

      S_DRIVE: begin
        // sample_q marks the cycle after step_en, when the datapath's crash flags are valid.
        if (sample_q && (bus.p1_crash || bus.p2_crash)) begin
          state_d    = S_COLL;
          step_cnt_d = {STEP_W{1'b0}};
          case ({bus.p1_crash, bus.p2_crash})
            2'b01: begin
              winner_d   = 2'b01;
              p1_score_d = sat_inc(p1_score_q);
            end
            2'b10: begin
              winner_d   = 2'b10;
              p2_score_d = sat_inc(p2_score_q);
            end
            2'b11: begin
              winner_d = 2'b11;
`ifdef TRON_DRAW_NOSCORE_EN
              p1_score_d = p1_score_q;
              p2_score_d = p2_score_q;
`else
              p1_score_d = sat_inc(p1_score_q);
              p2_score_d = sat_inc(p2_score_q);
`endif
            end
            default: begin
              winner_d = winner_q;
            end
          endcase
        end else begin
          // step_en is registered: it is high in the cycle after the counter reaches STEP_LAST.
          sample_d = step_en_q;
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = {STEP_W{1'b0}};
            step_en_d  = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + {{(STEP_W-1){1'b0}}, 1'b1};
          end
        end
      end

      S_COLL: begin
        if (bus.start_ack) begin
          if ((p1_score_q == WIN) || (p2_score_q == WIN)) begin
            state_d = S_DONE;
          end else begin
            state_d       = S_COUNT;
            arena_clear_d = 1'b1;
            countdown_d   = 2'd3;
            cd_cnt_d      = {CD_W{1'b0}};
          end
        end else begin
          state_d = S_COLL;
        end
      end

      S_DONE: begin
        if (bus.start_ack) begin
          state_d = S_I;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_I;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_I;
      cd_cnt_q      <= {CD_W{1'b0}};
      step_cnt_q    <= {STEP_W{1'b0}};
      step_en_q     <= 1'b0;
      sample_q      <= 1'b0;
      arena_clear_q <= 1'b0;
      countdown_q   <= 2'd0;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      cd_cnt_q      <= cd_cnt_d;
      step_cnt_q    <= step_cnt_d;
      step_en_q     <= step_en_d;
      sample_q      <= sample_d;
      arena_clear_q <= arena_clear_d;
      countdown_q   <= countdown_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      winner_q      <= winner_d;
    end
  end

  assign bus.q_I          = state_q[4];
  assign bus.q_Count      = state_q[3];
  assign bus.q_Driving    = state_q[2];
  assign bus.q_Collision  = state_q[1];
  assign bus.q_Done       = state_q[0];
  assign bus.step_en      = step_en_q;
  assign bus.arena_clear  = arena_clear_q;
  assign bus.countdown    = countdown_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.round_winner = winner_q;

endmodule

// File: tb/tb_tron_round_ctrl.sv
// tb_tron_round_ctrl
//   Directed testbench for tron_round_ctrl with the default parameters: STEP_DIV=4, CD_TICKS=8, WIN_SCORE=3.
//   Inputs change just after a falling edge; outputs are compared at falling edges.
module tb_tron_round_ctrl;

  localparam logic [4:0] F_I    = 5'b10000;
  localparam logic [4:0] F_CNT  = 5'b01000;
  localparam logic [4:0] F_DRV  = 5'b00100;
  localparam logic [4:0] F_COL  = 5'b00010;
  localparam logic [4:0] F_DONE = 5'b00001;

  logic board_clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses;

  tron_round_if bus ();

  tron_round_ctrl #(.STEP_DIV(4), .CD_TICKS(8), .WIN_SCORE(3)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  always #5 board_clk = ~board_clk;

  logic [4:0] flags;
  assign flags = {bus.q_I, bus.q_Count, bus.q_Driving, bus.q_Collision, bus.q_Done};

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle start_ack pulse; returns at the falling edge after it was taken.
  task automatic ack();
    bus.start_ack = 1'b1;
    @(negedge board_clk);
    bus.start_ack = 1'b0;
  endtask

  // From COUNT cycle 0: run the countdown, then present crashes in the first sample cycle.
  task automatic run_round(input logic c1, input logic c2);
    repeat (24) @(negedge board_clk);
    check_eq("drive_entry", {27'd0, flags}, {27'd0, F_DRV});
    repeat (5) @(negedge board_clk);
    bus.p1_crash = c1;
    bus.p2_crash = c2;
    @(negedge board_clk);
    bus.p1_crash = 1'b0;
    bus.p2_crash = 1'b0;
    check_eq("coll_entry", {27'd0, flags}, {27'd0, F_COL});
  endtask

  initial begin
    Reset         = 1'b1;
    bus.start_ack = 1'b0;
    bus.p1_crash  = 1'b0;
    bus.p2_crash  = 1'b0;
    repeat (3) @(negedge board_clk);

    // Reset state.
    check_eq("rst_flags",  {27'd0, flags}, {27'd0, F_I});
    check_eq("rst_step",   {31'd0, bus.step_en}, 32'd0);
    check_eq("rst_clear",  {31'd0, bus.arena_clear}, 32'd0);
    check_eq("rst_cd",     {30'd0, bus.countdown}, 32'd0);
    check_eq("rst_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'd0);
    check_eq("rst_winner", {30'd0, bus.round_winner}, 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge board_clk);
    check_eq("idle_hold", {27'd0, flags}, {27'd0, F_I});

    // First round: countdown timing, with an ignored ack in the middle of COUNT.
    ack();
    for (int c = 0; c < 24; c++) begin
      check_eq("cnt_state", {27'd0, flags}, {27'd0, F_CNT});
      check_eq("cnt_digit", {30'd0, bus.countdown}, 32'(3 - c / 8));
      check_eq("cnt_clear", {31'd0, bus.arena_clear}, (c == 0) ? 32'd1 : 32'd0);
      bus.start_ack = (c == 10);
      @(negedge board_clk);
    end
    // DRIVE: step_en every 4 cycles starting at k=4. Crashes are off-sample, plus an ignored ack.
    for (int k = 0; k < 14; k++) begin
      check_eq("drv_state",  {27'd0, flags}, {27'd0, F_DRV});
      check_eq("drv_cd",     {30'd0, bus.countdown}, 32'd0);
      check_eq("drv_step",   {31'd0, bus.step_en}, (k != 0 && k % 4 == 0) ? 32'd1 : 32'd0);
      check_eq("drv_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'd0);
      bus.p2_crash  = (k == 2 || k == 4 || k == 13);
      bus.start_ack = (k == 6);
      @(negedge board_clk);
    end
    bus.p2_crash  = 1'b0;
    bus.start_ack = 1'b0;
    check_eq("r1_state",  {27'd0, flags}, {27'd0, F_COL});
    check_eq("r1_winner", {30'd0, bus.round_winner}, 32'd1);
    check_eq("r1_p1",     {28'd0, bus.p1_score}, 32'd1);
    check_eq("r1_p2",     {28'd0, bus.p2_score}, 32'd0);
    check_eq("r1_step",   {31'd0, bus.step_en}, 32'd0);

    // Rounds two and three go to P1; the match ends on the third ack.
    ack();
    check_eq("r2_state", {27'd0, flags}, {27'd0, F_CNT});
    check_eq("r2_clear", {31'd0, bus.arena_clear}, 32'd1);
    check_eq("r2_cd",    {30'd0, bus.countdown}, 32'd3);
    run_round(1'b0, 1'b1);
    check_eq("r2_p1", {28'd0, bus.p1_score}, 32'd2);
    ack();
    run_round(1'b0, 1'b1);
    check_eq("r3_p1", {28'd0, bus.p1_score}, 32'd3);
    ack();
    check_eq("done_state",  {27'd0, flags}, {27'd0, F_DONE});
    check_eq("done_p1",     {28'd0, bus.p1_score}, 32'd3);
    check_eq("done_winner", {30'd0, bus.round_winner}, 32'd1);
    ack();
    check_eq("back_idle",  {27'd0, flags}, {27'd0, F_I});
    check_eq("idle_p1",    {28'd0, bus.p1_score}, 32'd3);
    ack();
    check_eq("restart_state",  {27'd0, flags}, {27'd0, F_CNT});
    check_eq("restart_p1",     {28'd0, bus.p1_score}, 32'd0);
    check_eq("restart_winner", {30'd0, bus.round_winner}, 32'd0);

    // Build up to 2/2, then both players crash.
    run_round(1'b1, 1'b0);
    check_eq("p2win_winner", {30'd0, bus.round_winner}, 32'd2);
    check_eq("p2win_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'h01);
    ack();
    run_round(1'b0, 1'b1);
    ack();
    run_round(1'b1, 1'b0);
    ack();
    run_round(1'b0, 1'b1);
    check_eq("pre_draw", {24'd0, bus.p1_score, bus.p2_score}, 32'h22);
    ack();
    run_round(1'b1, 1'b1);
    check_eq("draw_winner", {30'd0, bus.round_winner}, 32'd3);
`ifdef TRON_DRAW_NOSCORE_EN
    check_eq("draw_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'h22);
    ack();
    check_eq("draw_next", {27'd0, flags}, {27'd0, F_CNT});
`else
    check_eq("draw_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'h33);
    ack();
    check_eq("draw_next", {27'd0, flags}, {27'd0, F_DONE});
    ack();
    ack();
`endif

    // Reset asserted mid-COUNT takes effect without waiting for a clock edge.
    repeat (10) @(negedge board_clk);
    #2 Reset = 1'b1;
    #1;
    check_eq("rc_flags",  {27'd0, flags}, {27'd0, F_I});
    check_eq("rc_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'd0);
    check_eq("rc_cd",     {30'd0, bus.countdown}, 32'd0);
    @(negedge board_clk);
    Reset = 1'b0;

    // Reset mid-DRIVE, one cycle before a step_en, with a nonzero score.
    ack();
    run_round(1'b0, 1'b1);
    ack();
    repeat (27) @(negedge board_clk);
    check_eq("rd_pre", {27'd0, flags}, {27'd0, F_DRV});
    #2 Reset = 1'b1;
    #1;
    check_eq("rd_flags",  {27'd0, flags}, {27'd0, F_I});
    check_eq("rd_scores", {24'd0, bus.p1_score, bus.p2_score}, 32'd0);
    check_eq("rd_winner", {30'd0, bus.round_winner}, 32'd0);
    check_eq("rd_step",   {31'd0, bus.step_en}, 32'd0);
    @(negedge board_clk);
    Reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge board_clk);
      pulses += int'(bus.step_en) + int'(bus.arena_clear);
    end
    check_eq("post_rst_pulses", 32'(pulses), 32'd0);
    check_eq("post_rst_idle",   {27'd0, flags}, {27'd0, F_I});
    ack();
    check_eq("post_rst_start", {27'd0, flags}, {27'd0, F_CNT});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
